// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam int          ITER_COUNT    = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

  // Absolute value for signed ops; unsigned ops pass the operand through.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation of a 64-bit {hi,lo} pair, either as a
// whole (product) or per half (quotient and remainder).
module muldiv_sign_fix (
  input  logic [63:0] value,
  input  logic        neg_all,
  input  logic        neg_hi,
  input  logic        neg_lo,
  output logic [63:0] result
);

  always_comb begin
    result = value;
    if (neg_all) begin
      result = ~value + 64'd1;
    end else begin
      if (neg_hi) result[63:32] = ~value[63:32] + 32'd1;
      if (neg_lo) result[31:0]  = ~value[31:0] + 32'd1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 multiply/divide unit: 32 shift-add or restoring steps on magnitudes,
// then a sign-fix cycle. Define MULDIV_FAST_MULT_EN for single-cycle multiplies.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  state_e      state, state_nxt;
  op_e         op_r;
  logic [31:0] opa_r, opb_r;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] step_acc;
  logic [63:0] fix_src;
  logic [63:0] fixed;
  logic [31:0] b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic        is_div, a_neg, b_neg, div0, fast_in;

  assign is_div = op_is_div(op_r);
  assign b_mag  = magnitude(opb_r, op_is_signed(op_r));
  assign a_neg  = op_is_signed(op_r) & opa_r[31];
  assign b_neg  = op_is_signed(op_r) & opb_r[31];
  assign div0   = is_div & (opb_r == 32'd0);
  assign busy   = (state != ST_IDLE);

`ifdef MULDIV_FAST_MULT_EN
  logic [31:0] a_mag;
  assign a_mag   = magnitude(opa_r, op_is_signed(op_r));
  assign fast_in = ~op[1];
  assign fix_src = is_div ? acc : (64'(a_mag) * 64'(b_mag));
`else
  assign fast_in = 1'b0;
  assign fix_src = acc;
`endif

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (!is_div)
      step_acc = {mul_sum, acc[31:1]};
    else if (div_diff[32])
      step_acc = {div_shift[31:0], acc[30:0], 1'b0};
    else
      step_acc = {div_diff[31:0], acc[30:0], 1'b1};
  end

  muldiv_sign_fix u_sign_fix (
    .value   (fix_src),
    .neg_all (~is_div & (a_neg ^ b_neg)),
    .neg_hi  (is_div & a_neg),
    .neg_lo  (is_div & (a_neg ^ b_neg)),
    .result  (fixed)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = fast_in ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt == 5'(ITER_COUNT - 1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_r        <= OP_MULT;
      opa_r       <= '0;
      opb_r       <= '0;
      cnt         <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          op_r  <= op_e'(op);
          opa_r <= opa;
          opb_r <= opb;
          cnt   <= '0;
          acc   <= {32'd0, magnitude(opa, op_is_signed(op_e'(op)))};
        end
        ST_CALC: begin
          acc <= step_acc;
          cnt <= cnt + 5'd1;
        end
        ST_FIX: begin
          done        <= 1'b1;
          div_by_zero <= div0;
          if (div0) begin
            hi <= opa_r;
            lo <= DIV0_QUOTIENT;
          end else begin
            hi <= fixed[63:32];
            lo <= fixed[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have input clock, 1 bit: system clock; all state updates on its rising edge.
REQ-002 The block SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have input start, 1 bit: request pulse, sampled on a rising edge.
REQ-004 The block SHALL have input op, 2 bits: 00 mult, 01 multu, 10 div, 11 divu.
REQ-005 The block SHALL have input opa, 32 bits: rs operand (multiplicand or dividend).
REQ-006 The block SHALL have input opb, 32 bits: rt operand (multiplier or divisor).
REQ-007 The block SHALL have output busy, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have output done, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have output hi, 32 bits: product[63:32] or remainder.
REQ-010 The block SHALL have output lo, 32 bits: product[31:0] or quotient.
REQ-011 The block SHALL have output div_by_zero, 1 bit: flag for the last completed divide.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and FIX; reset enters IDLE.
REQ-013 In IDLE, start=1 on edge E0 SHALL latch op, opa and opb, load iteration counter 0, go to CALC and set busy=1.
REQ-014 CALC SHALL perform one radix-2 step per edge on E1..E32: shift-add for multiply, restoring subtract-shift for divide, all on magnitudes.
REQ-015 Counter reaching 31 on E32 SHALL move to FIX.
REQ-016 FIX on E33 SHALL apply sign correction, register hi/lo, set done=1, set busy=0 and return to IDLE; latency is 33 cycles.
REQ-017 done SHALL be high for exactly the one cycle after E33.
REQ-018 start while busy=1 SHALL be ignored, with no effect on operands or state.
REQ-019 start in the done cycle (FSM already in IDLE) SHALL be accepted; hi/lo keep the finished result until the next FIX.
REQ-020 hi/lo SHALL hold their value between completions; they never show intermediate values.
REQ-021 mult/div SHALL treat operands as two's complement; multu/divu SHALL treat them as unsigned.
REQ-022 Signed divide SHALL truncate the quotient toward zero; the remainder takes the dividend's sign.
REQ-023 0x80000000 div 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-024 Divisor 0 SHALL give lo=0xFFFFFFFF, hi=opa and div_by_zero=1, with unchanged latency.
REQ-025 div_by_zero SHALL update only in FIX: it is cleared by any non-zero divide or any multiply.

Reset
REQ-026 reset SHALL clear busy, done, hi, lo, div_by_zero, the counter and operand registers to 0 and force IDLE, asynchronously.
REQ-027 reset during CALC/FIX SHALL abort the operation; no done pulse follows.

Configuration
REQ-028 When MULDIV_FAST_MULT_EN is defined, mult/multu SHALL compute in a single combinational multiply; FIX is entered on E1 and done is high after E1 (latency 1); divides are unchanged.
REQ-029 When MULDIV_FAST_MULT_EN is undefined, all ops SHALL use the iterative 33-cycle path.

Structure
REQ-030 Package muldiv_pkg SHALL hold the op encodings, the FSM state encoding, ITER_COUNT=32 and the DIV0_QUOTIENT=0xFFFFFFFF constant.
REQ-031 Sub-module muldiv_sign_fix SHALL perform the conditional 64-bit two's-complement negation of {hi,lo} used in FIX.

Verification
REQ-032 multu 0xFFFFFFFF,0xFFFFFFFF SHALL give hi=0xFFFFFFFE, lo=0x00000001, with done exactly 33 cycles after start.
REQ-033 mult 0xFFFFFFFD,7 (-3*7) SHALL give hi=0xFFFFFFFF, lo=0xFFFFFFEB; with MULDIV_FAST_MULT_EN defined, the same result SHALL appear after 1 cycle.
REQ-034 div 0xFFFFFFF9,2 (-7/2) SHALL give lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100,7 SHALL give lo=14, hi=2.
REQ-035 divu 5,0 SHALL give lo=0xFFFFFFFF, hi=5, div_by_zero=1; a following multu 2,3 SHALL give lo=6, hi=0, div_by_zero=0.
REQ-036 div 0x80000000,0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-037 reset at cycle 10 of divu SHALL give busy=0, hi=lo=0 and no done; a start during busy SHALL be ignored, leaving the first op's result intact.
